// File: rtl/bhand_src.sv
// bhand_src: packet transmitter for the buffered-handshake stream interface.
// On a start command it reads len_words words from a synchronous-read RAM
// and streams them out with a per-word byte count and a last flag.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i                    one-cycle command to begin a packet
//   len_words_i, last_bytes_i  packet length (words) and bytes in final word (0 = full)
//   busy_o, done_o             packet in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_o         RAM read strobe and address
//   rd_data_i                  RAM data, valid the cycle after rd_en_o
//   odata_o, odata_vld_o       stream data and valid
//   odata_rdy_i                stream ready
//   ocount_o, olast_o          valid bytes in the current word, final-word marker
module bhand_src #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned COUNT_WIDTH  = 4,
  parameter bit          ENABLE_COUNT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  len_words_i,
  input  logic [COUNT_WIDTH-1:0] last_bytes_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   rd_en_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr_o,
  input  logic [DATA_WIDTH-1:0]  rd_data_i,
  output logic [DATA_WIDTH-1:0]  odata_o,
  output logic                   odata_vld_o,
  input  logic                   odata_rdy_i,
  output logic [COUNT_WIDTH-1:0] ocount_o,
  output logic                   olast_o
);

  localparam int unsigned             BYTES    = DATA_WIDTH / 8;
  localparam logic [COUNT_WIDTH-1:0]  FULL_CNT = COUNT_WIDTH'(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                   rd_last_q, rd_last_d;   // tags the read of the final word
  logic                   rv_q, rv_d;             // rd_data_i carries a word this cycle
  logic                   rv_last_q, rv_last_d;
  logic [ADDR_WIDTH-1:0]  len_q, len_d;
  logic [COUNT_WIDTH-1:0] lastb_q, lastb_d;
  logic [ADDR_WIDTH-1:0]  iss_q, iss_d;           // reads issued so far
  logic [DATA_WIDTH-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [COUNT_WIDTH-1:0] head_cnt_q, head_cnt_d, skid_cnt_q, skid_cnt_d;
  logic                   head_last_q, head_last_d, skid_last_q, skid_last_d;
  logic                   head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;

  logic                   hs;
  logic [COUNT_WIDTH-1:0] arr_cnt;
  logic [1:0]             occ_nx;
  logic                   can_issue;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_last_q   <= 1'b0;
      rv_q        <= 1'b0;
      rv_last_q   <= 1'b0;
      len_q       <= '0;
      lastb_q     <= '0;
      iss_q       <= '0;
      head_data_q <= '0;
      head_cnt_q  <= '0;
      head_last_q <= 1'b0;
      head_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_cnt_q  <= '0;
      skid_last_q <= 1'b0;
      skid_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_last_q   <= rd_last_d;
      rv_q        <= rv_d;
      rv_last_q   <= rv_last_d;
      len_q       <= len_d;
      lastb_q     <= lastb_d;
      iss_q       <= iss_d;
      head_data_q <= head_data_d;
      head_cnt_q  <= head_cnt_d;
      head_last_q <= head_last_d;
      head_vld_q  <= head_vld_d;
      skid_data_q <= skid_data_d;
      skid_cnt_q  <= skid_cnt_d;
      skid_last_q <= skid_last_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  // Next-state: buffer update, read issue and packet sequencing
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_last_d   = 1'b0;
    rv_d        = rd_en_q;
    rv_last_d   = rd_last_q;
    len_d       = len_q;
    lastb_d     = lastb_q;
    iss_d       = iss_q;
    head_data_d = head_data_q;
    head_cnt_d  = head_cnt_q;
    head_last_d = head_last_q;
    head_vld_d  = head_vld_q;
    skid_data_d = skid_data_q;
    skid_cnt_d  = skid_cnt_q;
    skid_last_d = skid_last_q;
    skid_vld_d  = skid_vld_q;

    hs = head_vld_q & odata_rdy_i;

    if (!ENABLE_COUNT) begin
      arr_cnt = '0;
    end else if (rv_last_q && (lastb_q != '0)) begin
      arr_cnt = lastb_q;
    end else begin
      arr_cnt = FULL_CNT;
    end

    // Retire the head first, then place the arriving word behind whatever remains
    if (hs) begin
      if (skid_vld_q) begin
        head_data_d = skid_data_q;
        head_cnt_d  = skid_cnt_q;
        head_last_d = skid_last_q;
        skid_vld_d  = 1'b0;
      end else begin
        head_vld_d  = 1'b0;
      end
    end
    if (rv_q) begin
      if (!head_vld_d) begin
        head_data_d = rd_data_i;
        head_cnt_d  = arr_cnt;
        head_last_d = rv_last_q;
        head_vld_d  = 1'b1;
      end else begin
        skid_data_d = rd_data_i;
        skid_cnt_d  = arr_cnt;
        skid_last_d = rv_last_q;
        skid_vld_d  = 1'b1;
      end
    end

    // Buffered words plus the read still in the RAM pipe must leave room for one more
    occ_nx    = 2'(head_vld_d) + 2'(skid_vld_d) + 2'(rd_en_q);
    can_issue = (occ_nx < 2'd2);

    case (state_q)
      S_IDLE: begin
        if (start_i && (len_words_i != '0)) begin
          len_d     = len_words_i;
          lastb_d   = last_bytes_i;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          iss_d     = ADDR_WIDTH'(1);
          rd_last_d = (len_words_i == ADDR_WIDTH'(1));
          state_d   = rd_last_d ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        if (can_issue) begin
          rd_en_d   = 1'b1;
          rd_addr_d = iss_q;
          iss_d     = iss_q + ADDR_WIDTH'(1);
          rd_last_d = (iss_q == (len_q - ADDR_WIDTH'(1)));
          if (rd_last_d) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (hs && head_last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign odata_o     = head_data_q;
  assign odata_vld_o = head_vld_q;
  assign ocount_o    = head_cnt_q;
  assign olast_o     = head_last_q;

endmodule

// File: tb/tb_bhand_src.sv
// Scoreboard bench for bhand_src with a behavioural synchronous-read RAM.
module tb_bhand_src;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  logic          clk, rst_n;
  logic          start;
  logic [AW-1:0] len_words;
  logic [CW-1:0] last_bytes;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] odata;
  logic          odata_vld, odata_rdy;
  logic [CW-1:0] ocount;
  logic          olast;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  exp_t          sb [$];
  int            n_chk = 0, n_pass = 0;
  int            rdy_mode = 3;
  int            n_iss = 0, n_xfer = 0, rd_pulses = 0;
  logic [AW-1:0] exp_addr = '0;
  logic          exp_done = 1'b0, stall_prev = 1'b0;
  logic [DW-1:0] sv_data;
  logic [CW:0]   sv_meta;

  bhand_src #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .ENABLE_COUNT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .len_words_i(len_words),
    .last_bytes_i(last_bytes), .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data), .odata_o(odata),
    .odata_vld_o(odata_vld), .odata_rdy_i(odata_rdy), .ocount_o(ocount), .olast_o(olast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Ready pattern generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       odata_rdy = 1'b1;
      1:       odata_rdy = ~odata_rdy;
      2:       odata_rdy = 1'b0;
      default: odata_rdy = 1'($urandom);
    endcase
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Output monitor: scoreboard pop, address sequence, done timing, stability
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("done", done, exp_done);
      if (exp_done) check("busy_at_done", busy, 0);
      exp_done = 1'b0;
      if (rd_en) begin
        check("rd_addr", rd_addr, exp_addr);
        exp_addr = exp_addr + 1'b1;
        n_iss++;
        rd_pulses++;
      end
      check("occ_le2", (n_iss - n_xfer) <= 2, 1);
      if (stall_prev) begin
        check("hold_vld", odata_vld, 1);
        check("hold_data", odata, sv_data);
        check("hold_meta", {ocount, olast}, sv_meta);
      end
      if (odata_vld && odata_rdy) begin
        if (sb.size() == 0) begin
          check("extra_word", odata_vld, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("odata", odata, e.data);
          check("ocount", ocount, e.cnt);
          check("olast", olast, e.last);
          if (e.last) exp_done = 1'b1;
        end
        n_xfer++;
      end
      stall_prev = odata_vld && !odata_rdy;
      sv_data    = odata;
      sv_meta    = {ocount, olast};
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_data"}, odata, 0);
    check({tag, "_ctl"}, {busy, done, rd_en, odata_vld, olast, rd_addr, ocount}, 0);
  endtask

  task automatic launch(input int len, input int lb);
    @(posedge clk); #1;
    exp_addr  = '0;
    n_iss     = 0;
    n_xfer    = 0;
    rd_pulses = 0;
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.data = mem[i];
      e.last = (i == len - 1);
      e.cnt  = (e.last && lb != 0) ? CW'(lb) : CW'(DW / 8);
      sb.push_back(e);
    end
    start = 1'b1; len_words = AW'(len); last_bytes = CW'(lb);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("lat_rd_en", rd_en, 1);
    check("lat_busy", busy, 1);
    @(negedge clk);
    check("lat_vld_e1", odata_vld, 0);
    @(negedge clk);
    check("lat_vld_e2", odata_vld, 1);
  endtask

  task automatic poke_start(input int len);
    @(posedge clk); #1;
    start = 1'b1; len_words = AW'(len); last_bytes = CW'(3);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got2;
    rst_n = 1'b0; start = 1'b0; len_words = '0; last_bytes = '0; odata_rdy = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 64'h1111 * 64'(i + 1);

    // 1: reset with random inputs, then release idle
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'($urandom); len_words = AW'($urandom); last_bytes = CW'($urandom);
      @(negedge clk);
      check_zero("rst");
    end
    @(posedge clk); #1;
    start = 1'b0; rdy_mode = 0; rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_zero("idle");
    end

    // 2: basic packet, ready held high
    launch(4, 3);
    wait_done("t2");

    // 3: toggling ready
    @(negedge clk); rdy_mode = 1;
    launch(6, 5);
    wait_done("t3");

    // 4: ready low for 8 cycles after start
    @(negedge clk); rdy_mode = 2;
    launch(8, 2);
    repeat (5) @(negedge clk);
    check("stall_reads", rd_pulses, 2);
    rdy_mode = 0;
    wait_done("t4");

    // 5: single full word, then a zero-length start
    launch(1, 0);
    wait_done("t5");
    poke_start(0);
    repeat (4) begin
      @(negedge clk);
      check("len0_quiet", {busy, rd_en, odata_vld}, 0);
    end

    // 6a: start pulsed mid-packet is ignored
    @(negedge clk); rdy_mode = 1;
    launch(6, 1);
    poke_start(2);
    wait_done("t6a");

    // 6b: reset after two words aborts; next packet restarts at address 0
    @(negedge clk); rdy_mode = 0;
    launch(8, 0);
    got2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_xfer >= 2) begin got2 = 1'b1; break; end
      @(negedge clk);
    end
    check("two_words", got2, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_abort", {done, busy}, 0);
    end
    launch(2, 4);
    wait_done("t6b");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
